alu_cmd_issuer: RTL and testbench

- Command-side driver for the 8-bit combinational ALU. It generates the ALU's ctrl/x/y inputs and consumes its out/carry outputs.
- Accepts one instruction at a time over a valid/ready handshake.
- Reads the two source operands from an internal 8x8-bit register file, presents them to the ALU, and writes the ALU result back to the destination register.
- Keeps a carry flag. Sits between the testbench/controller instruction source and the ALU.

---
 rtl/alu_cmd_issuer.sv | 196 +++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: command-side driver for the 8-bit combinational ALU.
// Accepts one instruction at a time over valid/ready. Source operands come
// from an internal register file and are presented to the ALU on registered
// ctrl/x/y outputs. The ALU result is written back to the destination register.
// Optional build macro: ALU_CHECK_EN adds an internal reference model that
// checks every ALU result and raises a sticky 'mismatch' flag.
module alu_cmd_issuer #(
  parameter int NREG = 8,
  parameter int DW   = 8,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  output logic [3:0]    alu_ctrl,
  output logic [DW-1:0] alu_x,
  output logic [DW-1:0] alu_y,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          carry_flag,
  output logic          mismatch
);

  // ALU opcode encoding
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOR = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_RL  = 4'd10;
  localparam logic [3:0] OP_RR  = 4'd11;
  localparam logic [3:0] OP_EQ  = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          accept;
  logic [AW-1:0] rd_lat;
  logic [DW-1:0] regs [NREG];
  logic          is_arith;

  // The in-flight opcode is held on alu_ctrl, so it also decides carry capture.
  assign is_arith = (alu_ctrl == OP_ADD) || (alu_ctrl == OP_SUB);

  // Debug read port: combinational, shows the pre-edge value during a write.
  assign rd_data = regs[rd_addr];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake/strobe decode
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        next_state = WB;
      end
      WB: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Capture opcode, operands and destination at acceptance; hold them otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl <= '0;
      alu_x    <= '0;
      alu_y    <= '0;
      rd_lat   <= '0;
    end else if (accept) begin
      alu_ctrl <= in_op;
      alu_x    <= regs[in_rs1];
      alu_y    <= regs[in_rs2];
      rd_lat   <= in_rd;
    end
  end

  // Register file: direct loads any time, writeback overrides a same-address load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (load_en) begin
        regs[load_addr] <= load_data;
      end
      if (done) begin
        regs[rd_lat] <= alu_out;
      end
    end
  end

  // Carry flag follows only ADD/SUB writebacks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_flag <= 1'b0;
    end else if (done && is_arith) begin
      carry_flag <= alu_carry;
    end
  end

`ifdef ALU_CHECK_EN
  logic [DW:0] expected;
  logic        mismatch_q;

  // Reference ALU: result in [DW-1:0], carry (ADD/SUB only) in bit DW
  function automatic logic [DW:0] ref_alu(input logic [3:0] op,
                                          input logic [DW-1:0] x,
                                          input logic [DW-1:0] y);
    logic [DW:0] res;
    res = '0;
    case (op)
      OP_ADD: res = {1'b0, x} + {1'b0, y};
      OP_SUB: res = {1'b0, x} - {1'b0, y};
      OP_AND: res[DW-1:0] = x & y;
      OP_OR:  res[DW-1:0] = x | y;
      OP_NOT: res[DW-1:0] = ~x;
      OP_XOR: res[DW-1:0] = x ^ y;
      OP_NOR: res[DW-1:0] = ~(x | y);
      OP_SLL: res[DW-1:0] = {x[DW-2:0], 1'b0};
      OP_SRL: res[DW-1:0] = {1'b0, x[DW-1:1]};
      OP_SRA: res[DW-1:0] = {x[DW-1], x[DW-1:1]};
      OP_RL:  res[DW-1:0] = {x[DW-2:0], x[DW-1]};
      OP_RR:  res[DW-1:0] = {x[0], x[DW-1:1]};
      OP_EQ:  res[0] = (x == y);
      default: res = '0;
    endcase
    return res;
  endfunction

  // Expected result from the latched op/operands
  always_comb begin
    expected = ref_alu(alu_ctrl, alu_x, alu_y);
  end

  // Sticky error flag, evaluated on the writeback cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
    end else if (done) begin
      if ((alu_out != expected[DW-1:0]) ||
          (is_arith && (alu_carry != expected[DW]))) begin
        mismatch_q <= 1'b1;
      end
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Testbench for alu_cmd_issuer. Provides a behavioural ALU on the DUT's
// ctrl/x/y -> out/carry interface and a register-level reference model.
`timescale 1ns/1ps
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [2:0] in_rd, in_rs1, in_rs2;
  logic       load_en;
  logic [2:0] load_addr;
  logic [7:0] load_data;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_x, alu_y, alu_out;
  logic       alu_carry;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       done;
  logic       carry_flag;
  logic       mismatch;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_regs [8];
  logic       model_carry;
  bit         corrupt = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .done(done), .carry_flag(carry_flag), .mismatch(mismatch)
  );

  // Behavioural ALU semantics written from the opcode table
  function automatic void alu_ref(input logic [3:0] op, input logic [7:0] x,
                                  input logic [7:0] y, output logic [7:0] r,
                                  output logic c);
    c = 1'b0;
    case (op)
      4'd0: begin r = x + y; c = (int'(x) + int'(y)) > 255; end
      4'd1: begin r = x - y; c = (x < y); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = ~x;
      4'd5: r = x ^ y;
      4'd6: r = ~(x | y);
      4'd7: r = x << 1;
      4'd8: r = x >> 1;
      4'd9: r = (x >> 1) | (x & 8'h80);
      4'd10: r = (x << 1) | (x >> 7);
      4'd11: r = (x >> 1) | (x << 7);
      4'd12: r = (x == y) ? 8'h01 : 8'h00;
      default: r = 8'h00;
    endcase
  endfunction

  // The ALU the DUT drives; non-arithmetic carry is deliberately junk
  always_comb begin
    logic [7:0] r;
    logic       c;
    alu_ref(alu_ctrl, alu_x, alu_y, r, c);
    alu_out   = corrupt ? ~r : r;
    alu_carry = (alu_ctrl < 4'd2) ? c : ^alu_x;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Model effect of one instruction, evaluated at acceptance
  task automatic predict(input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2);
    logic [7:0] r;
    logic       c;
    alu_ref(op, model_regs[rs1], model_regs[rs2], r, c);
    if (corrupt) r = ~r;
    model_regs[rd] = r;
    if (op < 4'd2) model_carry = c;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic do_load(input logic [2:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    model_regs[a] = d;
  endtask

  // Issue one instruction from IDLE; lat = edges from acceptance to done, -1 if none
  task automatic do_instr(input logic [3:0] op, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2,
                          output int lat);
    int cnt;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    lat = -1;
    for (int i = 0; i < 8 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    if (in_ready) predict(op, rd, rs1, rs2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (!done && cnt < 8) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (done) lat = cnt;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
    model_carry = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", in_ready); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    total++; if (carry_flag !== 1'b0) begin bad++; $display("[TB] FAIL reset_carry: got %b want 0", carry_flag); end
    total++; if (mismatch !== 1'b0) begin bad++; $display("[TB] FAIL reset_mismatch: got %b want 0", mismatch); end
    total++; if ({alu_ctrl, alu_x, alu_y} !== 20'h0) begin bad++; $display("[TB] FAIL reset_alu: got %h want 00000", {alu_ctrl, alu_x, alu_y}); end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), d);
      total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL reset_reg%0d: got %h want 00", i, d); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat;
    logic [7:0] d;
    do_load(3'd1, 8'h0F);
    do_load(3'd2, 8'hF3);
    do_instr(4'd0, 3'd3, 3'd1, 3'd2, lat);
    total++; if (lat != 2) begin bad++; $display("[TB] FAIL add_latency: got %0d want 2", lat); end
    read_reg(3'd3, d);
    total++; if (d !== 8'h02) begin bad++; $display("[TB] FAIL add_result: got %h want 02", d); end
    total++; if (carry_flag !== 1'b1) begin bad++; $display("[TB] FAIL add_carry: got %b want 1", carry_flag); end
    total++; if ({alu_ctrl, alu_x, alu_y} !== {4'd0, 8'h0F, 8'hF3}) begin bad++; $display("[TB] FAIL alu_hold: got %h want 00ff3", {alu_ctrl, alu_x, alu_y}); end
  endtask

  task automatic test_sub_and();
    int lat;
    logic [7:0] d;
    do_load(3'd4, 8'h05);
    do_load(3'd5, 8'h07);
    do_instr(4'd1, 3'd6, 3'd4, 3'd5, lat);
    read_reg(3'd6, d);
    total++; if (d !== 8'hFE) begin bad++; $display("[TB] FAIL sub_result: got %h want fe", d); end
    total++; if (carry_flag !== 1'b1) begin bad++; $display("[TB] FAIL sub_carry: got %b want 1", carry_flag); end
    do_instr(4'd2, 3'd0, 3'd4, 3'd5, lat);
    read_reg(3'd0, d);
    total++; if (d !== 8'h05) begin bad++; $display("[TB] FAIL and_result: got %h want 05", d); end
    total++; if (carry_flag !== 1'b1) begin bad++; $display("[TB] FAIL and_carry_kept: got %b want 1", carry_flag); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [3] = '{4'd0, 4'd5, 4'd1};
    logic [2:0] rds [3] = '{3'd4, 3'd5, 3'd1};
    logic [2:0] r1s [3] = '{3'd1, 3'd4, 3'd5};
    logic [2:0] r2s [3] = '{3'd2, 3'd1, 3'd1};
    int acc [$];
    int k = 0, dones = 0, lows = 0;
    logic [7:0] d;
    in_valid = 1'b1; in_op = ops[0]; in_rd = rds[0]; in_rs1 = r1s[0]; in_rs2 = r2s[0];
    for (int c = 0; c < 12; c++) begin
      bit took;
      took = 1'b0;
      if (c < 9 && !in_ready) lows++;
      if (in_valid && in_ready) begin
        acc.push_back(c);
        predict(ops[k], rds[k], r1s[k], r2s[k]);
        k++;
        took = 1'b1;
      end
      @(posedge clk); #1;
      if (took) begin
        if (k < 3) begin
          in_op = ops[k]; in_rd = rds[k]; in_rs1 = r1s[k]; in_rs2 = r2s[k];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (done) dones++;
    end
    in_valid = 1'b0;
    total++; if (acc.size() != 3) begin bad++; $display("[TB] FAIL b2b_accepts: got %0d want 3", acc.size()); end
    for (int i = 0; i < 3 && i < acc.size(); i++) begin
      total++; if (acc[i] != 3 * i) begin bad++; $display("[TB] FAIL b2b_accept_cycle%0d: got %0d want %0d", i, acc[i], 3 * i); end
    end
    total++; if (dones != 3) begin bad++; $display("[TB] FAIL b2b_dones: got %0d want 3", dones); end
    total++; if (lows != 6) begin bad++; $display("[TB] FAIL b2b_ready_low: got %0d want 6", lows); end
    for (int i = 0; i < 3; i++) begin
      read_reg(rds[i], d);
      total++; if (d !== model_regs[rds[i]]) begin bad++; $display("[TB] FAIL b2b_reg%0d: got %h want %h", rds[i], d, model_regs[rds[i]]); end
    end
    total++; if (carry_flag !== model_carry) begin bad++; $display("[TB] FAIL b2b_carry: got %b want %b", carry_flag, model_carry); end
    @(posedge clk); #1;
  endtask

  task automatic test_wb_collision();
    logic [7:0] pre3, d;
    pre3 = model_regs[3];
    // OR r3 = r1 | r2; r1 is overwritten while the instruction is in flight
    in_valid = 1'b1; in_op = 4'd3; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd2;
    predict(4'd3, 3'd3, 3'd1, 3'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    load_en = 1'b1; load_addr = 3'd1; load_data = 8'h3C;
    @(posedge clk); #1;
    model_regs[1] = 8'h3C;
    total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL wb_done: got %b want 1", done); end
    load_en = 1'b1; load_addr = 3'd3; load_data = 8'hAA;
    read_reg(3'd3, d);
    total++; if (d !== pre3) begin bad++; $display("[TB] FAIL wb_pre_edge_read: got %h want %h", d, pre3); end
    @(posedge clk); #1;
    load_en = 1'b0;
    read_reg(3'd3, d);
    total++; if (d !== model_regs[3]) begin bad++; $display("[TB] FAIL wb_wins: got %h want %h", d, model_regs[3]); end
    read_reg(3'd1, d);
    total++; if (d !== 8'h3C) begin bad++; $display("[TB] FAIL inflight_load_r1: got %h want 3c", d); end
    // second instruction, load to a different register during WB
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 4'd5; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd2;
    predict(4'd5, 3'd3, 3'd1, 3'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = 3'd7; load_data = 8'hAA;
    @(posedge clk); #1;
    load_en = 1'b0;
    model_regs[7] = 8'hAA;
    read_reg(3'd7, d);
    total++; if (d !== 8'hAA) begin bad++; $display("[TB] FAIL wb_other_load: got %h want aa", d); end
    read_reg(3'd3, d);
    total++; if (d !== model_regs[3]) begin bad++; $display("[TB] FAIL wb_other_result: got %h want %h", d, model_regs[3]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int dones = 0, notready = 0;
    logic [7:0] d;
    do_load(3'd1, 8'h81);
    do_load(3'd2, 8'h42);
    in_valid = 1'b1; in_op = 4'd5; in_rd = 3'd6; in_rs1 = 3'd1; in_rs2 = 3'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL midrst_done: got %b want 0", done); end
    total++; if ({alu_ctrl, alu_x, alu_y} !== 20'h0) begin bad++; $display("[TB] FAIL midrst_alu: got %h want 00000", {alu_ctrl, alu_x, alu_y}); end
    total++; if (carry_flag !== 1'b0) begin bad++; $display("[TB] FAIL midrst_carry: got %b want 0", carry_flag); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
    model_carry = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (!in_ready) notready++;
    end
    total++; if (dones != 0) begin bad++; $display("[TB] FAIL midrst_no_done: got %0d want 0", dones); end
    total++; if (notready != 0) begin bad++; $display("[TB] FAIL midrst_ready: got %0d want 0", notready); end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), d);
      total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL midrst_reg%0d: got %h want 00", i, d); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat;
    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    logic [7:0] d;
    for (int i = 0; i < 8; i++) do_load(3'(i), 8'($urandom));
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) do_load(3'($urandom_range(0, 7)), 8'($urandom));
      op = 4'($urandom_range(0, 15));
      rd = 3'($urandom_range(0, 7));
      rs1 = 3'($urandom_range(0, 7));
      rs2 = 3'($urandom_range(0, 7));
      do_instr(op, rd, rs1, rs2, lat);
      read_reg(rd, d);
      total++; if (lat != 2 || d !== model_regs[rd]) begin bad++; $display("[TB] FAIL rand_op%0d: got lat=%0d r%0d=%h want lat=2 %h", op, lat, rd, d, model_regs[rd]); end
      total++; if (carry_flag !== model_carry) begin bad++; $display("[TB] FAIL rand_carry_op%0d: got %b want %b", op, carry_flag, model_carry); end
    end
  endtask

  task automatic test_check_feature();
    int lat;
`ifdef ALU_CHECK_EN
    total++; if (mismatch !== 1'b0) begin bad++; $display("[TB] FAIL chk_clean: got %b want 0", mismatch); end
    do_load(3'd1, 8'h5A);
    corrupt = 1'b1;
    do_instr(4'd12, 3'd0, 3'd1, 3'd1, lat);
    corrupt = 1'b0;
    total++; if (mismatch !== 1'b1) begin bad++; $display("[TB] FAIL chk_detect: got %b want 1", mismatch); end
    do_instr(4'd0, 3'd2, 3'd1, 3'd1, lat);
    total++; if (mismatch !== 1'b1) begin bad++; $display("[TB] FAIL chk_sticky: got %b want 1", mismatch); end
`else
    do_instr(4'd12, 3'd0, 3'd1, 3'd1, lat);
    total++; if (mismatch !== 1'b0) begin bad++; $display("[TB] FAIL chk_tied_low: got %b want 0", mismatch); end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_and();
    test_back_to_back();
    test_wb_collision();
    test_reset_mid();
    test_random();
    test_check_feature();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
